// File: rtl/scan_uart_arbiter.sv
// Shares one UART TX between NCH ADC channels and frames each scan with HEAD/TAIL bytes.
// Optional SCAN_CSUM_EN adds an XOR checksum byte after TAIL.
module scan_uart_arbiter #(
    parameter int          NCH       = 4,
    parameter logic [7:0]  HEAD_BYTE = 8'hAA,
    parameter logic [7:0]  TAIL_BYTE = 8'h55
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH*32-1:0] adc_data,
    input  logic [NCH-1:0]    adc_valid,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              tx_empty,
    output logic              ld_tx_data,
    output logic [7:0]        tx_data,
    output logic              tx_enable,
    output logic [NCH-1:0]    overrun,
    output logic              busy
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
`ifdef SCAN_CSUM_EN
    localparam logic [2:0] CSUM      = 3'd4;
    localparam logic [1:0] K_CSUM    = 2'd3;
`endif
    localparam logic [1:0] K_HEAD    = 2'd0;
    localparam logic [1:0] K_TAIL    = 2'd1;
    localparam logic [1:0] K_DATA    = 2'd2;

    logic [2:0]     state_q, state_d;
    logic [1:0]     kind_q, kind_d;
    logic [2:0]     idx_q, idx_d;
    logic [2:0]     chan_q, chan_d;
    logic [31:0]    shift_q, shift_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] overrun_q, overrun_d;
    logic           head_req_q, head_req_d;
    logic           tail_req_q, tail_req_d;
    logic [2:0]     rr_q, rr_d;
    logic           tx_enable_q, tx_enable_d;
    logic [31:0]    hold_q [NCH];
    logic [31:0]    hold_d [NCH];
`ifdef SCAN_CSUM_EN
    logic [7:0]     csum_q, csum_d;
`endif

    logic [NCH-1:0] grant;
    logic [7:0]     cur_byte;
    logic           found;
    int             gsel;
    int             cand;

    always_comb begin
        case (kind_q)
            K_HEAD:  cur_byte = HEAD_BYTE;
            K_TAIL:  cur_byte = TAIL_BYTE;
            K_DATA:  cur_byte = (idx_q == 3'd0) ? {5'b0, chan_q} : shift_q[31:24];
`ifdef SCAN_CSUM_EN
            K_CSUM:  cur_byte = csum_q;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

`ifdef SCAN_CSUM_EN
    assign ld_tx_data = (state_q == LOAD) || (state_q == CSUM);
`else
    assign ld_tx_data = (state_q == LOAD);
`endif
    assign tx_data   = ld_tx_data ? cur_byte : 8'h00;
    assign tx_enable = tx_enable_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE) || head_req_q || tail_req_q || (|pend_q);

    // Round-robin search starting at rr_q, wrapping at NCH.
    always_comb begin
        found = 1'b0;
        gsel  = 0;
        cand  = 0;
        for (int k = 0; k < NCH; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NCH) cand = cand - NCH;
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        idx_d       = idx_q;
        chan_d      = chan_q;
        shift_d     = shift_q;
        overrun_d   = overrun_q;
        rr_d        = rr_q;
        head_req_d  = head_req_q | frame_start;
        tail_req_d  = tail_req_q | frame_end;
        tx_enable_d = 1'b1;
        grant       = '0;
        hold_d      = hold_q;
`ifdef SCAN_CSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_empty) begin
                    if (head_req_q) begin
                        head_req_d = frame_start;
                        kind_d     = K_HEAD;
                        state_d    = LOAD;
`ifdef SCAN_CSUM_EN
                        csum_d     = 8'h00;
`endif
                    end else if (found) begin
                        grant[gsel] = 1'b1;
                        kind_d      = K_DATA;
                        idx_d       = 3'd0;
                        chan_d      = 3'(gsel);
                        shift_d     = hold_q[gsel];
                        rr_d        = (gsel == NCH - 1) ? 3'd0 : 3'(gsel + 1);
                        state_d     = LOAD;
                    end else if (tail_req_q) begin
                        tail_req_d = frame_end;
                        kind_d     = K_TAIL;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
`ifdef SCAN_CSUM_EN
                csum_d = csum_q ^ cur_byte;
`endif
                if (kind_q == K_DATA && idx_q != 3'd0) shift_d = {shift_q[23:0], 8'h00};
                state_d = WAIT_BUSY;
            end
`ifdef SCAN_CSUM_EN
            CSUM: state_d = WAIT_BUSY;
`endif
            WAIT_BUSY: begin
                if (!tx_empty) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_empty) begin
                    if (kind_q == K_DATA && idx_q != 3'd4) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = LOAD;
`ifdef SCAN_CSUM_EN
                    end else if (kind_q == K_TAIL) begin
                        kind_d  = K_CSUM;
                        state_d = CSUM;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture in the grant cycle keeps pend set; the grant already took the old word.
        pend_d = (pend_q & ~grant) | adc_valid;
        for (int i = 0; i < NCH; i++) begin
            if (adc_valid[i]) begin
                hold_d[i] = adc_data[32*i +: 32];
                if (pend_q[i] && !grant[i]) overrun_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            kind_q      <= K_HEAD;
            idx_q       <= 3'd0;
            chan_q      <= 3'd0;
            shift_q     <= 32'h0;
            pend_q      <= '0;
            overrun_q   <= '0;
            head_req_q  <= 1'b0;
            tail_req_q  <= 1'b0;
            rr_q        <= 3'd0;
            tx_enable_q <= 1'b0;
`ifdef SCAN_CSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            idx_q       <= idx_d;
            chan_q      <= chan_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            head_req_q  <= head_req_d;
            tail_req_q  <= tail_req_d;
            rr_q        <= rr_d;
            tx_enable_q <= tx_enable_d;
`ifdef SCAN_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        hold_q <= hold_d;
    end
endmodule

// File: tb/tb_scan_uart_arbiter.sv
// Directed bench for scan_uart_arbiter with a 10-cycle-busy UART model and byte collector.
module tb_scan_uart_arbiter;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] adc_data = '0;
    logic [3:0]   adc_valid = '0;
    logic         frame_start = 1'b0;
    logic         frame_end = 1'b0;
    logic         tx_empty = 1'b1;
    logic         ld_tx_data;
    logic [7:0]   tx_data;
    logic         tx_enable;
    logic [3:0]   overrun;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] rxq [$];
    int   ld_wide = 0;
    logic prev_ld = 1'b0;
`ifdef SCAN_CSUM_EN
    logic [7:0] model_csum = 8'h00;
`endif

    typedef struct {
        logic [3:0]   vld;
        logic [127:0] dat;
        logic         fs;
        logic         fe;
        int           n;
        logic [159:0] exp;
    } rec_t;
    rec_t tbl [6];

    scan_uart_arbiter #(.NCH(4), .HEAD_BYTE(8'hAA), .TAIL_BYTE(8'h55)) dut (
        .clock(clock), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
        .frame_start(frame_start), .frame_end(frame_end), .tx_empty(tx_empty),
        .ld_tx_data(ld_tx_data), .tx_data(tx_data), .tx_enable(tx_enable),
        .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ld_tx_data) rxq.push_back(tx_data);
        if (ld_tx_data && prev_ld) ld_wide <= ld_wide + 1;
        prev_ld <= ld_tx_data;
    end

    // UART model: goes busy right after a load and stays busy for 10 cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (ld_tx_data) begin
                tx_empty = 1'b0;
                repeat (10) @(negedge clock);
                tx_empty = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v, input logic [127:0] d, input logic fs, input logic fe);
        adc_valid = v; adc_data = d; frame_start = fs; frame_end = fe;
        tick();
        adc_valid = '0; frame_start = 1'b0; frame_end = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check({name, " idle"}, 32'(busy), 32'd0);
        check({name, " tx_empty at idle"}, 32'(tx_empty), 32'd1);
    endtask

    task automatic expect_bytes(input string name, input logic [159:0] e, input int n);
        logic [31:0] act;
        check({name, " count"}, 32'(rxq.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            act = (k < rxq.size()) ? {24'h0, rxq[k]} : 32'hDEAD;
            check($sformatf("%s byte%0d", name, k), act, {24'h0, e[159-8*k -: 8]});
        end
    endtask

    task automatic run_rec(input string name, input rec_t r);
        logic [159:0] e;
        int n;
        e = r.exp;
        n = r.n;
`ifdef SCAN_CSUM_EN
        if (r.fs) model_csum = 8'h00;
        for (int k = 0; k < n; k++) model_csum = model_csum ^ e[159-8*k -: 8];
        if (r.fe) begin
            e[159-8*n -: 8] = model_csum;
            n++;
        end
`endif
        rxq.delete();
        pulse(r.vld, r.dat, r.fs, r.fe);
        wait_idle(name);
        expect_bytes(name, e, n);
    endtask

    initial begin
        logic [159:0] fin_exp;
        int           fin_n;
        int           n;

        tbl[0] = '{4'b1111, {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344}, 1'b0, 1'b0, 20,
                   160'h0011223344_0155667788_0299AABBCC_03DDEEFF00};
        tbl[1] = '{4'b1000, {32'h01020304, 96'h0}, 1'b0, 1'b0, 5, {40'h0301020304, 120'h0}};
        tbl[2] = '{4'b1001, {32'hF0F1F2F3, 64'h0, 32'h0A0B0C0D}, 1'b0, 1'b0, 10,
                   {80'h000A0B0C0D_03F0F1F2F3, 80'h0}};
        tbl[3] = '{4'b0001, {96'h0, 32'h12345678}, 1'b0, 1'b0, 5, {40'h0012345678, 120'h0}};
        tbl[4] = '{4'b1001, {32'hDEADBEEF, 64'h0, 32'hCAFEBABE}, 1'b0, 1'b0, 10,
                   {80'h03DEADBEEF_00CAFEBABE, 80'h0}};
        tbl[5] = '{4'b0100, {32'h0, 32'h89ABCDEF, 64'h0}, 1'b0, 1'b1, 6, {48'h0289ABCDEF55, 112'h0}};

        repeat (3) tick();
        check("rst ld_tx_data", 32'(ld_tx_data), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst tx_enable", 32'(tx_enable), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        check("tx_enable after reset", 32'(tx_enable), 32'd1);

        rxq.delete();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("head latency c1", 32'(ld_tx_data), 32'd0);
        tick();
        check("head latency c2", 32'(ld_tx_data), 32'd1);
        tick();
        check("head ld width", 32'(ld_tx_data), 32'd0);
        wait_idle("head");
        expect_bytes("head", {8'hAA, 152'h0}, 1);
`ifdef SCAN_CSUM_EN
        model_csum = 8'hAA;
`endif

        for (int i = 0; i < 6; i++) run_rec($sformatf("tbl%0d", i), tbl[i]);

        // Two captures on ch1 while the head byte is in flight: only the second is sent.
        rxq.delete();
        pulse(4'b0000, 128'h0, 1'b1, 1'b0);
        tick();
        tick();
        pulse(4'b0010, {64'h0, 32'hA0A1A2A3, 32'h0}, 1'b0, 1'b0);
        pulse(4'b0010, {64'h0, 32'hB0B1B2B3, 32'h0}, 1'b0, 1'b0);
        wait_idle("ovr");
        expect_bytes("ovr", {48'hAA01B0B1B2B3, 112'h0}, 6);
        check("overrun set", 32'(overrun), 32'h2);
        run_rec("ovr later", tbl[3]);
        check("overrun sticky", 32'(overrun), 32'h2);

        // Reset while byte 3 of a data packet is being loaded.
        rxq.delete();
        pulse(4'b0001, {96'h0, 32'h11111111}, 1'b0, 1'b0);
        n = 0;
        while (rxq.size() < 3 && n < 500) begin
            tick();
            n++;
        end
        check("midpkt reached byte3", 32'(rxq.size()), 32'd3);
        reset = 1'b1;
        tick();
        check("midrst ld_tx_data", 32'(ld_tx_data), 32'd0);
        check("midrst tx_data", 32'(tx_data), 32'd0);
        check("midrst tx_enable", 32'(tx_enable), 32'd0);
        check("midrst overrun", 32'(overrun), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (40) tick();
        check("no resume after reset", 32'(rxq.size()), 32'd3);

        // Complete frame after reset: HEAD, ch0 word, TAIL (+ checksum when enabled).
        rxq.delete();
        pulse(4'b0000, 128'h0, 1'b1, 1'b0);
        wait_idle("frame head");
        pulse(4'b0001, {96'h0, 32'h00000001}, 1'b0, 1'b0);
        wait_idle("frame data");
        pulse(4'b0000, 128'h0, 1'b0, 1'b1);
        wait_idle("frame tail");
`ifdef SCAN_CSUM_EN
        fin_exp = {56'hAA000000000155, 8'hFE, 96'h0};
        fin_n   = 8;
`else
        fin_exp = {56'hAA000000000155, 104'h0};
        fin_n   = 7;
`endif
        expect_bytes("frame", fin_exp, fin_n);
        check("ld_tx_data single-cycle", 32'(ld_wide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
